// File: rtl/dwc_pkg.sv
// Shared FSM state type, counter widths and helpers for the duplicated-path retry controller.
// The optional error tally is enabled with the DWC_ERR_COUNT_EN macro in dwc_retry_ctrl.
package dwc_pkg;

    localparam int RETRY_W   = 4;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OUT   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    // Saturating increment so the error tally sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (value == '1) ? value : value + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dwc_compare.sv
// Bitwise comparison of the two redundant data copies; any differing bit flags a mismatch.
module dwc_compare #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] copy_a,
    input  logic [WIDTH-1:0] copy_b,
    output logic             mismatch
);

    assign mismatch = |(copy_a ^ copy_b);

endmodule

// File: rtl/dwc_retry_ctrl.sv
// Duplicate-with-compare retry controller: loads two copies, compares, retries on mismatch, locks out.
// Define DWC_ERR_COUNT_EN to add the saturating port_err_count output.
module dwc_retry_ctrl
    import dwc_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 port_in_valid,
    input  logic [WIDTH-1:0]     port_in_data,
    output logic                 port_in_ready,
    input  logic                 port_inj,
    output logic                 port_out_valid,
    output logic [WIDTH-1:0]     port_out_data,
    input  logic                 port_out_ready,
    output logic                 port_error,
    output logic                 port_alarm
`ifdef DWC_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] port_err_count
`endif
);

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_t             state;
    logic [WIDTH-1:0]   copy0;
    logic [WIDTH-1:0]   copy1;
    logic [WIDTH-1:0]   inj_mask;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_next;
    logic               mismatch;

    dwc_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .copy_a  (copy0),
        .copy_b  (copy1),
        .mismatch(mismatch)
    );

    // The fault injector only ever corrupts bit 0 of the second copy.
    always_comb begin
        inj_mask    = '0;
        inj_mask[0] = port_inj;
    end

    assign retry_next    = retry_cnt + RETRY_W'(1);
    assign port_in_ready = (state == CHECK) && !mismatch;
    assign port_out_data = copy0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            copy0          <= '0;
            copy1          <= '0;
            retry_cnt      <= '0;
            port_error     <= 1'b0;
            port_alarm     <= 1'b0;
            port_out_valid <= 1'b0;
        end else begin
            port_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (port_in_valid) begin
                        copy0 <= port_in_data;
                        copy1 <= port_in_data ^ inj_mask;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // Upstream holds its data on a mismatch, so returning to IDLE reloads the same word.
                    if (mismatch) begin
                        port_error <= 1'b1;
                        retry_cnt  <= retry_next;
                        if (retry_next == RETRY_LIMIT) begin
                            port_alarm <= 1'b1;
                            state      <= LOCK;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        retry_cnt      <= '0;
                        port_out_valid <= 1'b1;
                        state          <= OUT;
                    end
                end
                OUT: begin
                    if (port_out_ready) begin
                        port_out_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                LOCK: begin
                    port_alarm     <= 1'b1;
                    port_out_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DWC_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (port_error) begin
            err_count <= err_sat_inc(err_count);
        end
    end

    assign port_err_count = err_count;
`else
    // Error pulses are not tallied in this build.
`endif

endmodule

// File: tb/tb_dwc_retry_ctrl.sv
// Randomized scoreboard bench for dwc_retry_ctrl (WIDTH=8, MAX_RETRY=3).
// With DWC_ERR_COUNT_EN defined it also checks saturation of port_err_count.
module tb_dwc_retry_ctrl;

    localparam int WIDTH     = 8;
    localparam int MAX_RETRY = 3;
    localparam int TXN_LIMIT = 200;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               lat;
        int               start;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             inj = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             error;
    logic             alarm;
`ifdef DWC_ERR_COUNT_EN
    logic [7:0]       err_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   err_base = 0;
    int   hs_count = 0;
    bit   ready_hold = 1'b0;
    bit   ready_random = 1'b0;
    exp_t exp_q[$];

    dwc_retry_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_in_valid (in_valid),
        .port_in_data  (in_data),
        .port_in_ready (in_ready),
        .port_inj      (inj),
        .port_out_valid(out_valid),
        .port_out_data (out_data),
        .port_out_ready(out_ready),
        .port_error    (error),
        .port_alarm    (alarm)
`ifdef DWC_ERR_COUNT_EN
        ,
        .port_err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // out_ready is settled shortly after each rising edge so the monitor and the DUT see the same value.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_hold ? 1'b0 : (ready_random ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    initial begin : monitor
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (error) err_seen++;
                if (in_ready) check_output("in_ready_with_valid_or_alarm", {out_valid, alarm}, 0);
                if (alarm) check_output("lock_out_valid", out_valid, 0);
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) check_output("spurious_out_valid", exp_q.size(), 1);
                    else check_output("latency", cyc - exp_q[0].start, exp_q[0].lat);
                end
                if (out_valid && exp_q.size() > 0) begin
                    check_output("out_data", out_data, exp_q[0].data);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    // One word through the controller; the first n_bad loads are corrupted by inj.
    task automatic apply_stimulus(input logic [WIDTH-1:0] d, input int n_bad, input bit stop_at_out,
                                  output bit locked);
        exp_t e;
        int   att;
        int   budget;
        bit   consumed;
        bit   will_lock;
        att       = 0;
        budget    = 0;
        consumed  = 1'b0;
        locked    = 1'b0;
        will_lock = (n_bad >= MAX_RETRY);
        e.data    = d;
        e.lat     = 2 + 2 * n_bad;
        e.start   = cyc;
        if (!will_lock) exp_q.push_back(e);
        err_exp  += will_lock ? MAX_RETRY : n_bad;
        in_valid  = 1'b1;
        in_data   = d;
        inj       = (n_bad > 0);
        forever begin
            @(negedge clk);
            budget++;
            if (budget > TXN_LIMIT) begin
                total++;
                bad++;
                $display("[TB] FAIL txn_timeout: waited %0d cycles, limit %0d", budget, TXN_LIMIT);
                in_valid = 1'b0;
                inj      = 1'b0;
                break;
            end
            if (consumed) in_valid = 1'b0;
            if (error) begin
                att++;
                inj = (att < n_bad);
            end
            if (in_ready) consumed = 1'b1;
            if (alarm) begin
                locked   = 1'b1;
                in_valid = 1'b0;
                inj      = 1'b0;
                break;
            end
            if (out_valid && stop_at_out) break;
            if (out_valid && out_ready) begin
                @(negedge clk);
                break;
            end
        end
    endtask

    task automatic reset_mid(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output({tag, "_rst_out_valid"}, out_valid, 0);
        check_output({tag, "_rst_error"}, error, 0);
        check_output({tag, "_rst_alarm"}, alarm, 0);
        check_output({tag, "_rst_in_ready"}, in_ready, 0);
        exp_q.delete();
        in_valid = 1'b0;
        inj      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        err_base = err_seen;
        rst_n    = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit locked;
        int start_hs;
        int err_before;

        repeat (3) @(negedge clk);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_error", error, 0);
        check_output("reset_alarm", alarm, 0);
        check_output("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        ready_random = 1'b0;
        apply_stimulus(8'hA5, 0, 1'b0, locked);
        check_output("clean_errors", err_seen, 0);
        apply_stimulus(8'h3C, 1, 1'b0, locked);
        check_output("single_fault_errors", err_seen, 1);
        check_output("single_fault_alarm", alarm, 0);

        ready_random = 1'b1;
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(WIDTH'($urandom), int'($urandom_range(0, MAX_RETRY - 1)), 1'b0, locked);
            check_output("random_not_locked", locked, 0);
        end
        check_output("random_errors", err_seen, err_exp);

        ready_random = 1'b0;
        ready_hold   = 1'b1;
        apply_stimulus(8'h5A, 0, 1'b1, locked);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_in_ready", in_ready, 0);
            check_output("bp_out_valid", out_valid, 1);
        end
        start_hs   = hs_count;
        ready_hold = 1'b0;
        for (int k = 0; k < 10 && hs_count == start_hs; k++) @(negedge clk);
        check_output("bp_handshake", hs_count, start_hs + 1);
        @(negedge clk);
        apply_stimulus(8'h77, 0, 1'b0, locked);

        ready_hold = 1'b1;
        apply_stimulus(8'h96, 0, 1'b1, locked);
        reset_mid("out");
        ready_hold   = 1'b0;
        ready_random = 1'b1;
        apply_stimulus(8'h11, 0, 1'b0, locked);
        check_output("after_out_reset_queue", exp_q.size(), 0);

        err_before = err_seen;
        apply_stimulus(8'hC3, 99, 1'b0, locked);
        check_output("lock_reached", locked, 1);
        @(negedge clk);
        check_output("lock_error_pulses", err_seen - err_before, MAX_RETRY);
        in_valid = 1'b1;
        in_data  = 8'h42;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("lock_alarm", alarm, 1);
            check_output("lock_in_ready", in_ready, 0);
        end
        check_output("lock_no_more_errors", err_seen - err_before, MAX_RETRY);
        reset_mid("lock");
        apply_stimulus(8'hE7, 0, 1'b0, locked);
        check_output("after_lock_alarm", alarm, 0);

`ifdef DWC_ERR_COUNT_EN
        check_output("errcnt_after_reset", err_count, err_seen - err_base);
        ready_random = 1'b0;
        for (int i = 0; i < 150; i++) begin
            apply_stimulus(WIDTH'($urandom), 2, 1'b0, locked);
        end
        @(negedge clk);
        check_output("errcnt_saturated", err_count,
                     ((err_seen - err_base) > 255) ? 255 : (err_seen - err_base));
        check_output("errcnt_model", err_exp - err_base >= 300, 1);
`endif

        repeat (4) @(negedge clk);
        check_output("final_errors", err_seen, err_exp);
        check_output("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
